// File: rtl/uart16750_ctrl.sv
// uart16750_ctrl: register-bus master for the uart_16750 core.
// Configures the core, then polls LSR to move bytes between streams and THR/RBR.
module uart16750_ctrl #(
  parameter logic [15:0] DIVISOR  = 16'h0011,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter logic [7:0]  FCR_VAL  = 8'h81,
  parameter logic [7:0]  IER_VAL  = 8'h01,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        clk_33M,
  input  logic        rstn,
  input  logic        reconfig,
  output logic        bus_cs,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [2:0]  bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        cfg_done,
  output logic [3:0]  err_flags,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    CFG, RUN_GAP, POLL, DECIDE, RX_RD, TX_WR
  } state_t;

  state_t      state;
  logic [3:0]  cfg_step;
  logic [15:0] gap_cnt;
  logic        rcfg_pend;
  logic        lsr_dr;
  logic        lsr_thre;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;

  // even steps 0..10 issue a write, odd steps idle, step 12 finishes
  always_comb begin
    cfg_addr = 3'd0;
    cfg_data = 8'h00;
    case (cfg_step[3:1])
      3'd0: begin cfg_addr = 3'd3; cfg_data = 8'h80 | LCR_VAL; end
      3'd1: begin cfg_addr = 3'd0; cfg_data = DIVISOR[7:0]; end
      3'd2: begin cfg_addr = 3'd1; cfg_data = DIVISOR[15:8]; end
      3'd3: begin cfg_addr = 3'd3; cfg_data = LCR_VAL; end
      3'd4: begin cfg_addr = 3'd2; cfg_data = FCR_VAL; end
      3'd5: begin cfg_addr = 3'd1; cfg_data = IER_VAL; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      state     <= CFG;
      cfg_step  <= 4'd0;
      gap_cnt   <= 16'd0;
      rcfg_pend <= 1'b0;
      lsr_dr    <= 1'b0;
      lsr_thre  <= 1'b0;
      bus_cs    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_addr  <= 3'd0;
      bus_dout  <= 8'h00;
      tx_ready  <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      cfg_done  <= 1'b0;
      err_flags <= 4'd0;
      tx_count  <= 16'd0;
      rx_count  <= 16'd0;
    end else begin
      bus_cs   <= 1'b0;
      bus_wr   <= 1'b0;
      bus_rd   <= 1'b0;
      tx_ready <= 1'b0;
      if (reconfig) rcfg_pend <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        CFG: begin
          if (cfg_step == 4'd12) begin
            cfg_done <= 1'b1;
            gap_cnt  <= 16'd0;
            state    <= RUN_GAP;
          end else begin
            if (!cfg_step[0]) begin
              bus_cs   <= 1'b1;
              bus_wr   <= 1'b1;
              bus_addr <= cfg_addr;
              bus_dout <= cfg_data;
            end
            cfg_step <= cfg_step + 4'd1;
          end
        end
        RUN_GAP: begin
          if (rcfg_pend) begin
            rcfg_pend <= reconfig;
            cfg_done  <= 1'b0;
            err_flags <= 4'd0;
            cfg_step  <= 4'd0;
            state     <= CFG;
          end else if (gap_cnt >= GAP_LAST) begin
            if (!rx_valid || tx_valid) begin
              bus_cs   <= 1'b1;
              bus_rd   <= 1'b1;
              bus_addr <= 3'd5;
              state    <= POLL;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        POLL: begin
          lsr_dr    <= bus_din[0];
          lsr_thre  <= bus_din[5];
          err_flags <= err_flags | bus_din[4:1];
          state     <= DECIDE;
        end
        DECIDE: begin
          if (lsr_dr && !rx_valid) begin
            bus_cs   <= 1'b1;
            bus_rd   <= 1'b1;
            bus_addr <= 3'd0;
            state    <= RX_RD;
          end else if (lsr_thre && tx_valid) begin
            bus_cs   <= 1'b1;
            bus_wr   <= 1'b1;
            bus_addr <= 3'd0;
            bus_dout <= tx_data;
            tx_ready <= 1'b1;
            state    <= TX_WR;
          end else begin
            gap_cnt <= 16'd0;
            state   <= RUN_GAP;
          end
        end
        RX_RD: begin
          rx_data  <= bus_din;
          rx_valid <= 1'b1;
          rx_count <= rx_count + 16'd1;
          gap_cnt  <= 16'd0;
          state    <= RUN_GAP;
        end
        TX_WR: begin
          tx_count <= tx_count + 16'd1;
          gap_cnt  <= 16'd0;
          state    <= RUN_GAP;
        end
        default: state <= CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_uart16750_ctrl.sv
// tb_uart16750_ctrl: UART register-file model, stream scoreboard and
// directed plus randomized scenarios for uart16750_ctrl.
module tb_uart16750_ctrl;

  localparam int PG = 16;

  logic        clk_33M = 1'b0;
  logic        rstn = 1'b1;
  logic        reconfig = 1'b0;
  logic        bus_cs, bus_wr, bus_rd;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        cfg_done;
  logic [3:0]  err_flags;
  logic [15:0] tx_count, rx_count;

  uart16750_ctrl #(.POLL_GAP(PG)) dut (
    .clk_33M(clk_33M), .rstn(rstn), .reconfig(reconfig),
    .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_done(cfg_done), .err_flags(err_flags),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk_33M = ~clk_33M;

  int checks = 0;
  int errors = 0;

  logic [7:0]  lsr_q[$];
  logic [7:0]  rbr_q[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  thr_log[$];
  logic [10:0] cfg_log[$];
  logic [10:0] cfg_exp[6] = '{
    {3'd3, 8'h83}, {3'd0, 8'h11}, {3'd1, 8'h00},
    {3'd3, 8'h03}, {3'd2, 8'h81}, {3'd1, 8'h01}
  };
  bit thre = 1'b1;
  bit pop_lsr = 1'b0;
  bit pop_rbr = 1'b0;
  bit prev_strobe = 1'b0;
  int cyc = 0;
  int last_strobe = -100;
  int last_poll = -100;
  int n_polls = 0;
  int n_rbr = 0;
  int rx_acc = 0;
  logic [7:0] mtmp;
  logic strobe;

  // UART register model and bus/stream scoreboard
  always @(negedge clk_33M) begin
    #1;
    if (pop_lsr) begin mtmp = lsr_q.pop_front(); pop_lsr = 1'b0; end
    if (pop_rbr) begin mtmp = rbr_q.pop_front(); pop_rbr = 1'b0; end
    strobe = bus_cs | bus_wr | bus_rd;
    if (rstn) begin
      cyc++;
      checks++;
      if ((bus_wr || bus_rd) && !bus_cs) begin
        errors++;
        $display("FAIL cs_with_strobe: cs=%b wr=%b rd=%b", bus_cs, bus_wr, bus_rd);
      end
      if (strobe) begin
        checks++;
        if (prev_strobe) begin
          errors++;
          $display("FAIL strobe_back_to_back: got consecutive strobes at cyc %0d", cyc);
        end
      end
      checks++;
      if (tx_ready !== (bus_cs && bus_wr && bus_addr == 3'd0 && cfg_done)) begin
        errors++;
        $display("FAIL tx_ready_align: tx_ready=%b cs=%b wr=%b addr=%0d", tx_ready, bus_cs, bus_wr, bus_addr);
      end
      if (tx_ready) begin
        checks++;
        if (bus_dout !== tx_data || !tx_valid) begin
          errors++;
          $display("FAIL thr_data: got %h want %h (tx_valid=%b)", bus_dout, tx_data, tx_valid);
        end
        thr_log.push_back(bus_dout);
      end
      if (bus_cs && bus_wr && !cfg_done) cfg_log.push_back({bus_addr, bus_dout});
      if (bus_cs && cfg_done) begin
        if (bus_rd && bus_addr == 3'd5) begin
          checks++;
          if (cyc - last_strobe < PG + 1) begin
            errors++;
            $display("FAIL poll_gap: got %0d want >= %0d", cyc - last_strobe, PG + 1);
          end
          n_polls++;
          last_poll = cyc;
          if (lsr_q.size() != 0) pop_lsr = 1'b1;
        end else begin
          checks++;
          if (cyc - last_poll != 2) begin
            errors++;
            $display("FAIL txn_after_poll: got %0d want 2", cyc - last_poll);
          end
          if (bus_rd && bus_addr == 3'd0) begin
            n_rbr++;
            checks++;
            if (rbr_q.size() == 0 || rx_valid) begin
              errors++;
              $display("FAIL rbr_read: got fifo=%0d rx_valid=%b want fifo>0 rx_valid=0", rbr_q.size(), rx_valid);
            end else begin
              exp_rx.push_back(rbr_q[0]);
              pop_rbr = 1'b1;
            end
          end
        end
      end
      if (strobe) last_strobe = cyc;
      prev_strobe = strobe;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_extra: got %h want nothing", rx_data);
        end else begin
          mtmp = exp_rx.pop_front();
          if (rx_data !== mtmp) begin
            errors++;
            $display("FAIL rx_data: got %h want %h", rx_data, mtmp);
          end
          rx_acc++;
        end
      end
    end else begin
      prev_strobe = 1'b0;
      last_strobe = -100;
      last_poll = -100;
    end
    if (bus_addr == 3'd5)
      bus_din = (lsr_q.size() != 0) ? lsr_q[0]
              : {1'b0, thre, thre, 4'b0000, rbr_q.size() != 0};
    else if (bus_addr == 3'd0)
      bus_din = (rbr_q.size() != 0) ? rbr_q[0] : 8'h00;
    else
      bus_din = 8'h00;
  end

  task automatic test_reset();
    bit s;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk_33M);
    checks++;
    if ({bus_cs, bus_wr, bus_rd, bus_addr, bus_dout, tx_ready, rx_data, rx_valid,
         cfg_done, err_flags, tx_count, rx_count} !== 61'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs want all zero");
    end
    rstn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_33M);
      s = (i % 2 == 0) && (i <= 10);
      checks++;
      if ({bus_cs, bus_wr, bus_rd} !== (s ? 3'b110 : 3'b000)) begin
        errors++;
        $display("FAIL cfg_strobe[%0d]: got %b want %b", i, {bus_cs, bus_wr, bus_rd}, s ? 3'b110 : 3'b000);
      end
      if (s) begin
        checks++;
        if ({bus_addr, bus_dout} !== cfg_exp[i / 2]) begin
          errors++;
          $display("FAIL cfg_write[%0d]: got %h want %h", i / 2, {bus_addr, bus_dout}, cfg_exp[i / 2]);
        end
      end
      checks++;
      if (cfg_done !== (i >= 12)) begin
        errors++;
        $display("FAIL cfg_done[%0d]: got %b want %b", i, cfg_done, i >= 12);
      end
    end
  endtask

  task automatic test_tx();
    bit seen = 1'b0;
    @(negedge clk_33M);
    tx_data = 8'h41;
    tx_valid = 1'b1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_33M);
      if (tx_ready) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tx_timeout: got no tx_ready want one");
    end else begin
      checks++;
      if ({bus_cs, bus_wr, bus_rd, bus_addr, bus_dout} !== {3'b110, 3'd0, 8'h41}) begin
        errors++;
        $display("FAIL thr_write: got %h want %h", {bus_cs, bus_wr, bus_rd, bus_addr, bus_dout}, {3'b110, 3'd0, 8'h41});
      end
    end
    @(negedge clk_33M);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_width: got %b want 0", tx_ready);
    end
    checks++;
    if (tx_count !== 16'd1) begin
      errors++;
      $display("FAIL tx_count_1: got %0d want 1", tx_count);
    end
  endtask

  task automatic test_rx_priority();
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk_33M);
      if (bus_cs && bus_rd && bus_addr == 3'd5) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL poll_timeout: got no LSR poll want one");
    end
    rbr_q.push_back(8'h5A);
    tx_data = 8'h42;
    tx_valid = 1'b1;
    repeat (2) @(negedge clk_33M);
    checks++;
    if ({bus_cs, bus_wr, bus_rd, bus_addr, tx_ready} !== {3'b101, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL rx_first: got %b want %b", {bus_cs, bus_wr, bus_rd, bus_addr, tx_ready}, {3'b101, 3'd0, 1'b0});
    end
    @(negedge clk_33M);
    checks++;
    if ({rx_valid, rx_data, rx_count, tx_count} !== {1'b1, 8'h5A, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL rx_capture: got v=%b d=%h rc=%0d tc=%0d want v=1 d=5a rc=1 tc=1", rx_valid, rx_data, rx_count, tx_count);
    end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk_33M);
      if (tx_ready) seen = 1'b1;
    end
    checks++;
    if (!seen || bus_dout !== 8'h42 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL tx_deferred: got seen=%b dout=%h rx_valid=%b want 1 42 1", seen, bus_dout, rx_valid);
    end
    @(negedge clk_33M);
    tx_valid = 1'b0;
    checks++;
    if (tx_count !== 16'd2) begin
      errors++;
      $display("FAIL tx_count_2: got %0d want 2", tx_count);
    end
  endtask

  task automatic test_backpressure();
    int p0 = n_polls;
    int r0 = n_rbr;
    bit seen = 1'b0;
    rbr_q.push_back(8'hA5);
    repeat (3 * (PG + 3)) @(negedge clk_33M);
    checks++;
    if (n_polls != p0 || n_rbr != r0) begin
      errors++;
      $display("FAIL idle_while_full: got polls=%0d reads=%0d want 0 0", n_polls - p0, n_rbr - r0);
    end
    tx_data = 8'h77;
    tx_valid = 1'b1;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk_33M);
      if (tx_ready) seen = 1'b1;
    end
    @(negedge clk_33M);
    tx_valid = 1'b0;
    checks++;
    if (!seen || n_rbr != r0 || tx_count !== 16'd3) begin
      errors++;
      $display("FAIL tx_under_backpressure: got seen=%b reads=%0d tc=%0d want 1 0 3", seen, n_rbr - r0, tx_count);
    end
    rx_ready = 1'b1;
    @(negedge clk_33M);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_valid_clear: got %b want 0", rx_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk_33M);
      if (rx_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || rx_data !== 8'hA5 || rx_count !== 16'd2) begin
      errors++;
      $display("FAIL rx_after_release: got seen=%b d=%h rc=%0d want 1 a5 2", seen, rx_data, rx_count);
    end
    rx_ready = 1'b1;
    @(negedge clk_33M);
    rx_ready = 1'b0;
    @(negedge clk_33M);
    checks++;
    if (rx_acc != 2) begin
      errors++;
      $display("FAIL rx_accepted: got %0d want 2", rx_acc);
    end
  endtask

  task automatic test_err_reconfig();
    int p0 = n_polls;
    bit seen = 1'b0;
    lsr_q.push_back(8'h02);
    for (int k = 0; k < 100 && n_polls == p0; k++) @(negedge clk_33M);
    @(negedge clk_33M);
    checks++;
    if (err_flags !== 4'b0001) begin
      errors++;
      $display("FAIL err_capture: got %b want 0001", err_flags);
    end
    for (int k = 0; k < 200 && n_polls < p0 + 3; k++) @(negedge clk_33M);
    checks++;
    if (err_flags !== 4'b0001 || n_polls < p0 + 3) begin
      errors++;
      $display("FAIL err_sticky: got %b polls=%0d want 0001 3", err_flags, n_polls - p0);
    end
    cfg_log.delete();
    reconfig = 1'b1;
    @(negedge clk_33M);
    reconfig = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (!cfg_done) seen = 1'b1;
      else @(negedge clk_33M);
    end
    checks++;
    if (!seen || err_flags !== 4'd0 || tx_count !== 16'd3 || rx_count !== 16'd2) begin
      errors++;
      $display("FAIL reconfig_take: got low=%b err=%b tc=%0d rc=%0d want 1 0000 3 2", seen, err_flags, tx_count, rx_count);
    end
    for (int k = 0; k < 40 && !cfg_done; k++) @(negedge clk_33M);
    checks++;
    if (!cfg_done || cfg_log.size() != 6) begin
      errors++;
      $display("FAIL reconfig_done: got done=%b writes=%0d want 1 6", cfg_done, cfg_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cfg_log[i] !== cfg_exp[i]) begin
          errors++;
          $display("FAIL recfg_write[%0d]: got %h want %h", i, cfg_log[i], cfg_exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midcfg();
    int nw = 0;
    reconfig = 1'b1;
    @(negedge clk_33M);
    reconfig = 1'b0;
    for (int k = 0; k < 100 && nw < 4; k++) begin
      @(negedge clk_33M);
      if (bus_cs && bus_wr && !cfg_done) nw++;
    end
    checks++;
    if (nw != 4 || {bus_addr, bus_dout} !== cfg_exp[3]) begin
      errors++;
      $display("FAIL midcfg_write3: got n=%0d %h want 4 %h", nw, {bus_addr, bus_dout}, cfg_exp[3]);
    end
    rstn = 1'b0;
    #2;
    checks++;
    if ({bus_cs, bus_wr, bus_rd, bus_addr, bus_dout, tx_ready, rx_data, rx_valid,
         cfg_done, err_flags, tx_count, rx_count} !== 61'd0) begin
      errors++;
      $display("FAIL async_reset: got nonzero outputs want all zero");
    end
    exp_rx.delete();
    @(negedge clk_33M);
    rstn = 1'b1;
    @(negedge clk_33M);
    checks++;
    if ({bus_cs, bus_wr, bus_rd, bus_addr, bus_dout} !== {3'b110, cfg_exp[0]}) begin
      errors++;
      $display("FAIL restart_lcr: got %h want %h", {bus_cs, bus_wr, bus_rd, bus_addr, bus_dout}, {3'b110, cfg_exp[0]});
    end
    for (int k = 0; k < 40 && !cfg_done; k++) @(negedge clk_33M);
  endtask

  task automatic test_random();
    localparam int N = 24;
    logic [7:0] tx_list[N];
    int a0 = rx_acc;
    thr_log.delete();
    for (int i = 0; i < N; i++) begin
      tx_list[i] = 8'($urandom);
      rbr_q.push_back(8'($urandom));
    end
    fork
      begin
        bit seen;
        @(negedge clk_33M);
        for (int i = 0; i < N; i++) begin
          tx_data = tx_list[i];
          tx_valid = 1'b1;
          seen = 1'b0;
          for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk_33M);
            if (tx_ready) seen = 1'b1;
          end
          @(negedge clk_33M);
          tx_valid = 1'b0;
          checks++;
          if (!seen) begin
            errors++;
            $display("FAIL rand_tx_timeout: got none want byte %0d", i);
            break;
          end
          repeat ($urandom_range(0, 2)) @(negedge clk_33M);
        end
      end
      begin
        for (int c = 0; c < 6000 && rx_acc - a0 < N; c++) begin
          @(negedge clk_33M);
          rx_ready = 1'($urandom_range(0, 1));
          thre = ($urandom_range(0, 3) != 0);
        end
        rx_ready = 1'b0;
        thre = 1'b1;
      end
    join
    repeat (2) @(negedge clk_33M);
    checks++;
    if (thr_log.size() != N) begin
      errors++;
      $display("FAIL rand_tx_bytes: got %0d want %0d", thr_log.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (thr_log[i] !== tx_list[i]) begin
          errors++;
          $display("FAIL rand_tx_order[%0d]: got %h want %h", i, thr_log[i], tx_list[i]);
        end
      end
    end
    checks++;
    if (rx_acc - a0 != N || rbr_q.size() != 0 || exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rand_rx: got acc=%0d left=%0d want %0d 0", rx_acc - a0, rbr_q.size(), N);
    end
    checks++;
    if (tx_count !== 16'(N) || rx_count !== 16'(N)) begin
      errors++;
      $display("FAIL rand_counts: got tc=%0d rc=%0d want %0d", tx_count, rx_count, N);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_priority();
    test_backpressure();
    test_err_reconfig();
    test_reset_midcfg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
